// File: rtl/fsm_pulse_counter.sv
// Counts qualifying data samples up to a run-time target and emits a one-cycle flag pulse.
// Optional macro FSM_EDGE_COUNT_EN switches from level counting to rising-edge counting.
module fsm_pulse_counter #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] target,
  output logic             flag,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  typedef enum logic {StCount, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             q;
  logic             term;
  logic             target_nz;
  logic [CNT_W:0]   cnt_inc;

`ifdef FSM_EDGE_COUNT_EN
  logic data_d;

  // Previous data sample, tracked regardless of en/clr so edges stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_d <= 1'b0;
    end else begin
      data_d <= data;
    end
  end

  assign q = en & data & ~data_d;
`else
  assign q = en & data;
`endif

  assign target_nz = |target;
  // One extra bit so cnt = 2^CNT_W-1 cannot overflow the compare.
  assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign term      = q & target_nz & (cnt_inc >= {1'b0, target});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StCount;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = 1'b0;
    unique case (state_q)
      StCount: begin
        if (clr) begin
          cnt_d = '0;
        end else if (term) begin
          flag_d = 1'b1;
          if (MODE == 1) begin
            cnt_d   = target;
            state_d = StDone;
          end else begin
            cnt_d = '0;
          end
        end else if (q && target_nz) begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      StDone: begin
        if (clr) begin
          cnt_d   = '0;
          state_d = StCount;
        end
      end
      default: begin
        state_d = StCount;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    flag = flag_q;
    cnt  = cnt_q;
    done = (MODE == 1) && (state_q == StDone);
  end

endmodule

// File: tb/tb_fsm_pulse_counter.sv
// Randomized + directed bench for fsm_pulse_counter; a MODE=0 and a MODE=1 instance share
// stimulus and are each compared against an integer reference model every cycle.
module tb_fsm_pulse_counter;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             data;
  logic             en;
  logic             clr;
  logic [CNT_W-1:0] target;
  logic             flag0, flag1;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic             done0, done1;

  int total = 0;
  int bad   = 0;

  // Reference model state, index = MODE
  int m_cnt[2];
  bit m_flag[2];
  bit m_done[2];
  bit m_prev;

  fsm_pulse_counter #(.CNT_W(CNT_W), .MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .data(data), .en(en), .clr(clr), .target(target),
    .flag(flag0), .cnt(cnt0), .done(done0)
  );

  fsm_pulse_counter #(.CNT_W(CNT_W), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .data(data), .en(en), .clr(clr), .target(target),
    .flag(flag1), .cnt(cnt1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m]  = 0;
      m_flag[m] = 1'b0;
      m_done[m] = 1'b0;
    end
    m_prev = 1'b0;
  endtask

  // One clock of the event rules, applied to the inputs sampled at the edge.
  task automatic model_step();
    bit qual;
    int t;
    t = int'(target);
`ifdef FSM_EDGE_COUNT_EN
    qual = en && data && !m_prev;
`else
    qual = en && data;
`endif
    for (int m = 0; m < 2; m++) begin
      m_flag[m] = 1'b0;
      if (m_done[m]) begin
        if (clr) begin
          m_cnt[m]  = 0;
          m_done[m] = 1'b0;
        end
      end else if (clr) begin
        m_cnt[m] = 0;
      end else if (qual && t != 0 && m_cnt[m] + 1 >= t) begin
        m_flag[m] = 1'b1;
        if (m == 1) begin
          m_cnt[m]  = t;
          m_done[m] = 1'b1;
        end else begin
          m_cnt[m] = 0;
        end
      end else if (qual && t != 0) begin
        m_cnt[m] = m_cnt[m] + 1;
      end
    end
    m_prev = data;
  endtask

  task automatic check_all();
    check("flag0", flag0, m_flag[0]);
    check("cnt0",  cnt0,  m_cnt[0]);
    check("done0", done0, 0);
    check("flag1", flag1, m_flag[1]);
    check("cnt1",  cnt1,  m_cnt[1]);
    check("done1", done1, m_done[1]);
  endtask

  // Drive inputs, let one edge sample them, then compare on the falling edge.
  task automatic step(input logic d, input logic e, input logic c, input logic [CNT_W-1:0] t);
    data   = d;
    en     = e;
    clr    = c;
    target = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear immediately.
  task automatic reset_pulse();
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    rst = 1'b1;
  endtask

  int pulses;
  logic [CNT_W-1:0] tgt;

  initial begin
    rst    = 1'b0;
    data   = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    target = 4'd4;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_cnt0",  cnt0,  0);
    check("rst_flag0", flag0, 0);
    check("rst_cnt1",  cnt1,  0);
    check("rst_flag1", flag1, 0);
    check("rst_done1", done1, 0);
    rst = 1'b1;

    // Continuous events, target 4: three pulses in twelve samples
    step(0, 1, 1, 4);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 4);
      if (flag0) pulses++;
    end
    check("pulses_t4", pulses, 3);

    // Alternating data, target 4
    step(0, 1, 1, 4);
    for (int i = 0; i < 7; i++) step(((i % 2) == 0), 1, 0, 4);
    step(0, 1, 0, 4);

    // One-shot: flag after third event, then hold in DONE until clr
    step(0, 1, 1, 3);
    for (int i = 0; i < 13; i++) step(1, 1, 0, 3);
    check("oneshot_done", done1, 1);
    check("oneshot_cnt",  cnt1,  3);
    step(1, 1, 1, 3);
    check("oneshot_clr_done", done1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 3);

    // en=0 holds, target=0 freezes, clr beats the terminal event
    step(0, 1, 1, 4);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 4);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 4);
    step(1, 1, 1, 4);
    check("clr_wins_flag", flag0, 0);

    // Lowering target below cnt makes the next event terminal
    step(0, 1, 1, 8);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 8);
    step(1, 1, 0, 3);
    check("lower_tgt_flag", flag0, 1);
    step(0, 1, 1, 8);
    step(1, 1, 0, 8);
    step(1, 1, 0, 8);
    reset_pulse();
    check("rst_mid_cnt", cnt0, 0);

    // Edge-count pattern (level counting unless FSM_EDGE_COUNT_EN)
    step(0, 1, 1, 2);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 2);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 2);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 2);

    // Randomized phase
    tgt = 4'd3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        tgt = (($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) :
               4'($urandom_range(0, 5)));
      end
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 23) == 0), tgt);
      if ($urandom_range(0, 99) == 0) reset_pulse();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
